// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// ALU encodings match the single-cycle core so both designs share one ALU.
package mc_controller_pkg;

  typedef logic       u1;
  typedef logic [1:0] u2;
  typedef logic [2:0] u3;
  typedef logic [3:0] u4;
  typedef logic [5:0] u6;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype_t;

  localparam u6 OP_LW    = 6'b100011;
  localparam u6 OP_SW    = 6'b101011;
  localparam u6 OP_RTYPE = 6'b000000;
  localparam u6 OP_BEQ   = 6'b000100;
  localparam u6 OP_ADDI  = 6'b001000;
  localparam u6 OP_J     = 6'b000010;

  localparam u6 FUNCT_ADD = 6'b100000;
  localparam u6 FUNCT_SUB = 6'b100010;
  localparam u6 FUNCT_AND = 6'b100100;
  localparam u6 FUNCT_OR  = 6'b100101;
  localparam u6 FUNCT_SLT = 6'b101010;

  localparam u3 ALU_AND = 3'b000;
  localparam u3 ALU_OR  = 3'b001;
  localparam u3 ALU_ADD = 3'b010;
  localparam u3 ALU_SUB = 3'b110;
  localparam u3 ALU_SLT = 3'b111;

  localparam u2 ALUOP_ADD   = 2'b00;
  localparam u2 ALUOP_SUB   = 2'b01;
  localparam u2 ALUOP_FUNCT = 2'b10;

  localparam u2 SRCB_REG   = 2'b00;
  localparam u2 SRCB_FOUR  = 2'b01;
  localparam u2 SRCB_IMM   = 2'b10;
  localparam u2 SRCB_IMMSH = 2'b11;

  localparam u2 PC_ALU    = 2'b00;
  localparam u2 PC_ALUOUT = 2'b01;
  localparam u2 PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU control decoder: aluop and funct to alucont.
// Behaviour is identical to the single-cycle decoder; unknown codes fall back to add.
module mc_controller_aludec
  import mc_controller_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucont = ALU_ADD;
          FUNCT_SUB: alucont = ALU_SUB;
          FUNCT_AND: alucont = ALU_AND;
          FUNCT_OR:  alucont = ALU_OR;
          FUNCT_SLT: alucont = ALU_SLT;
          default:   alucont = ALU_ADD;
        endcase
      end
      default:   alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath.
//   state   | meaning
//   FETCH   | read instr at PC, PC <= PC+4
//   DECODE  | read regs, precompute branch target
//   MEMADR  | compute lw/sw address
//   MEMRD   | read data memory
//   MEMWB   | write loaded word to rt
//   MEMWR   | write store data to memory
//   RTYPEEX | R-type ALU operation
//   RTYPEWB | write R-type result to rd
//   BEQEX   | compare, branch if zero
//   ADDIEX  | add immediate
//   ADDIWB  | write addi result to rt
//   JEX     | load jump target into PC
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucont,
  output logic       instr_done,
  output logic [3:0] state
);

  statetype_t state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch;
  logic       memwrite_s, irwrite_s, regwrite_s, done_s;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    done_s     = 1'b0;
    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        alusrcb   = SRCB_FOUR;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            // unknown opcode retires as a nop right here
            state_d = FETCH;
            done_s  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        state_d = MEMWB;
        iord    = 1'b1;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      RTYPEEX: begin
        state_d = RTYPEWB;
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
        done_s  = 1'b1;
      end
      ADDIEX: begin
        state_d = ADDIWB;
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      JEX: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
        done_s  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Enables are masked during reset so an aborted state cannot commit anything.
  assign memwrite   = memwrite_s & ~reset;
  assign irwrite    = irwrite_s  & ~reset;
  assign regwrite   = regwrite_s & ~reset;
  assign instr_done = done_s     & ~reset;
  assign pcen       = (pcwrite | (branch & zero)) & ~reset;
  assign state      = state_q;

  mc_controller_aludec u_aludec (
    .funct   (funct),
    .aluop   (aluop),
    .alucont (alucont)
  );

endmodule
